bcd_tick_counter: RTL and testbench

Two-digit BCD up/down counter that consumes the ~3 Hz square wave from the board clock divider and advances once per rising edge of that wave while running. It runs entirely on the 50 MHz board clock: the slow divider output and the board push-buttons/switch are treated as asynchronous inputs and synchronized internally. Its BCD output feeds the seven-segment display driver and LEDs downstream.

---
 rtl/bcd_tick_counter.sv | 196 +++++++++++++++++++
 tb/tb_bcd_tick_counter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_tick_counter.sv
// ---------------------------------------------------------------------------
// bcd_tick_counter
//   Two-digit BCD up/down counter that advances once per rising edge of a
//   slow (~3 Hz) divider output while in RUN. Everything runs on the board
//   clock; the divider output, buttons and direction switch are asynchronous
//   and are synchronized here before use.
//
// Parameters
//   MAX_BCD     terminal count in BCD (8'h01..8'h99, both nibbles <= 9)
//
// Ports
//   clk         board clock, all state on its rising edge
//   rst         asynchronous active-high reset
//   tick_in     slow divider output (async)
//   btn_start   start push-button level (async)
//   btn_stop    stop push-button level (async)
//   btn_load    load push-button level (async)
//   up_dn       direction switch, 1 = up, 0 = down (async)
//   load_val    BCD preload value, sampled only on a load event
//   count       current value, [7:4] tens, [3:0] units
//   running     high while in RUN
//   tick_pulse  one-cycle strobe per detected tick_in rising edge
//   wrap        one-cycle strobe when the count wraps
//   load_err    one-cycle strobe when a load is rejected
// ---------------------------------------------------------------------------
module bcd_tick_counter #(
    parameter logic [7:0] MAX_BCD = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_load,
    input  logic       up_dn,
    input  logic [7:0] load_val,
    output logic [7:0] count,
    output logic       running,
    output logic       tick_pulse,
    output logic       wrap,
    output logic       load_err
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bit positions inside the synchronizer vectors.
    localparam int B_TICK  = 0;
    localparam int B_START = 1;
    localparam int B_STOP  = 2;
    localparam int B_LOAD  = 3;
    localparam int B_UPDN  = 4;

    logic [4:0] w_async;
    logic [4:0] r_sync1;
    logic [4:0] r_sync2;
    logic [3:0] r_prev;
    logic [3:0] w_event;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_count;
    logic [7:0] w_count_nxt;
    logic       r_wrap;
    logic       w_wrap_nxt;
    logic       r_load_err;
    logic       w_load_err_nxt;

    // BCD +1; caller guarantees v < MAX_BCD so the tens digit cannot overflow.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = v[7:4];
        units = v[3:0];
        if (units == 4'd9) begin
            units = 4'd0;
            tens  = tens + 4'd1;
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

    // BCD -1; caller guarantees v > 8'h00 so the tens digit cannot underflow.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = v[7:4];
        units = v[3:0];
        if (units == 4'd0) begin
            units = 4'd9;
            tens  = tens - 4'd1;
        end else begin
            units = units - 4'd1;
        end
        return {tens, units};
    endfunction

    // With both nibbles <= 9, a plain binary compare orders BCD values correctly.
    function automatic logic bcd_load_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= MAX_BCD);
    endfunction

    assign w_async = {up_dn, btn_load, btn_stop, btn_start, tick_in};

    // Two-flop synchronizers plus a "previous" flop for edge detection.
    // Reset to 0 so a level held high across reset release gives one event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= w_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2[3:0];
        end
    end

    assign w_event = r_sync2[3:0] & ~r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stop is checked first so simultaneous start+stop ends in STOP.
    always_comb begin
        w_state_nxt = r_state;
        if (w_event[B_STOP]) begin
            w_state_nxt = ST_STOP;
        end else if (w_event[B_START]) begin
            w_state_nxt = ST_RUN;
        end
    end

    // Count/load decisions use the current state, so a tick arriving with a
    // stop still steps the count before the FSM leaves RUN.
    always_comb begin
        w_count_nxt    = r_count;
        w_wrap_nxt     = 1'b0;
        w_load_err_nxt = 1'b0;
        if (r_state == ST_RUN) begin
            if (w_event[B_TICK]) begin
                if (r_sync2[B_UPDN]) begin
                    if (r_count == MAX_BCD) begin
                        w_count_nxt = 8'h00;
                        w_wrap_nxt  = 1'b1;
                    end else begin
                        w_count_nxt = bcd_inc(r_count);
                    end
                end else begin
                    if (r_count == 8'h00) begin
                        w_count_nxt = MAX_BCD;
                        w_wrap_nxt  = 1'b1;
                    end else begin
                        w_count_nxt = bcd_dec(r_count);
                    end
                end
            end
        end else begin
            if (w_event[B_LOAD]) begin
                if (bcd_load_ok(load_val)) begin
                    w_count_nxt = load_val;
                end else begin
                    w_load_err_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= 8'h00;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_wrap     <= w_wrap_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    assign count      = r_count;
    assign running    = (r_state == ST_RUN);
    assign tick_pulse = w_event[B_TICK];
    assign wrap       = r_wrap;
    assign load_err   = r_load_err;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_tick_counter
//   Self-checking bench for bcd_tick_counter. Stimulus tasks compute the
//   expected outputs with a small decimal model and push them, tagged with the
//   cycle they are due, into a scoreboard queue; a monitor pops and compares
//   each entry when that cycle's outputs are stable.
//   Output word layout: {count[7:0], running, tick_pulse, wrap, load_err}.
// ---------------------------------------------------------------------------
module tb_bcd_tick_counter;

    localparam logic [7:0] MAX_BCD = 8'h59;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_in;
    logic       btn_start;
    logic       btn_stop;
    logic       btn_load;
    logic       up_dn;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       running;
    logic       tick_pulse;
    logic       wrap;
    logic       load_err;

    logic [11:0] obs;
    assign obs = {count, running, tick_pulse, wrap, load_err};

    bcd_tick_counter #(.MAX_BCD(MAX_BCD)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .btn_start  (btn_start),
        .btn_stop   (btn_stop),
        .btn_load   (btn_load),
        .up_dn      (up_dn),
        .load_val   (load_val),
        .count      (count),
        .running    (running),
        .tick_pulse (tick_pulse),
        .wrap       (wrap),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          due;
        logic [11:0] exp;
        logic [11:0] mask;
    } sb_t;

    sb_t sb_q[$];
    int  cyc_n    = 0;
    int  n_checks = 0;
    int  n_fails  = 0;

    // Bench model state
    logic [7:0] m_cnt;
    bit         m_run;
    bit         m_up;

    task automatic check(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        n_checks++;
        if (obs_v !== exp_v) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs_v, exp_v, $time);
        end
    endtask

    function automatic int b2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2b(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic bit load_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b2i(b) <= b2i(MAX_BCD));
    endfunction

    task automatic push(input string tag, input int due, input logic [11:0] exp, input logic [11:0] mask);
        sb_t e;
        e.tag  = tag;
        e.due  = due;
        e.exp  = exp;
        e.mask = mask;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every entry due this cycle, away from the clock edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc_n++;
            #2;
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].due == cyc_n) begin
                    check(sb_q[i].tag, 32'(obs & sb_q[i].mask), 32'(sb_q[i].exp & sb_q[i].mask));
                    sb_q.delete(i);
                end
            end
        end
    end

    // Drive any combination of events in the same cycle, 10 cycles high then
    // 10 low (a 20-cycle period for tick_in). Input set after edge t is first
    // sampled at t+1; strobe visible in cycle t+2; registered effect at t+3.
    task automatic ev(input string tag, input bit st, input bit sp, input bit ld,
                      input bit tk, input logic [7:0] lv);
        int         t;
        int         v;
        logic [7:0] nc;
        bit         nrun;
        bit         w;
        bit         e;
        @(posedge clk);
        #1;
        t    = cyc_n;
        nc   = m_cnt;
        w    = 1'b0;
        e    = 1'b0;
        if (tk && m_run) begin
            v = b2i(m_cnt);
            if (m_up) begin
                if (v == b2i(MAX_BCD)) begin v = 0; w = 1'b1; end
                else v = v + 1;
            end else begin
                if (v == 0) begin v = b2i(MAX_BCD); w = 1'b1; end
                else v = v - 1;
            end
            nc = i2b(v);
        end
        if (ld && !m_run) begin
            if (load_ok(lv)) nc = lv;
            else e = 1'b1;
        end
        nrun = sp ? 1'b0 : (st ? 1'b1 : m_run);

        load_val  = lv;
        btn_start = st;
        btn_stop  = sp;
        btn_load  = ld;
        tick_in   = tk;

        push({tag, "_strobe"}, t + 2, {m_cnt, m_run, tk, 1'b0, 1'b0}, 12'hFFF);
        push({tag, "_effect"}, t + 3, {nc, nrun, 1'b0, w, e}, 12'hFFF);
        push({tag, "_oneshot"}, t + 4, 12'h000, 12'h003);

        repeat (10) @(posedge clk);
        #1;
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        btn_load  = 1'b0;
        tick_in   = 1'b0;
        repeat (10) @(posedge clk);
        m_cnt = nc;
        m_run = nrun;
    endtask

    task automatic set_dir(input bit d);
        @(posedge clk);
        #1;
        up_dn = d;
        m_up  = d;
        repeat (5) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int t;
        rst       = 1'b1;
        tick_in   = 1'b0;
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        btn_load  = 1'b0;
        up_dn     = 1'b1;
        load_val  = 8'h00;
        m_cnt     = 8'h00;
        m_run     = 1'b0;
        m_up      = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(obs), 32'h0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("idle_after_reset", 32'(obs), 32'h0);

        // Start, then 10 up-ticks from 00.
        ev("start", 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) ev("tick_up", 0, 0, 0, 1, 8'h00);
        check("count_10", 32'(count), 32'h10);

        // Wrap up from 58 and wrap down from 00.
        ev("stop_a", 0, 1, 0, 0, 8'h00);
        ev("load_58", 0, 0, 1, 0, 8'h58);
        ev("start_b", 1, 0, 0, 0, 8'h00);
        ev("up_to_59", 0, 0, 0, 1, 8'h00);
        ev("wrap_up", 0, 0, 0, 1, 8'h00);
        set_dir(1'b0);
        ev("wrap_down", 0, 0, 0, 1, 8'h00);
        ev("down_58", 0, 0, 0, 1, 8'h00);

        // Loads in STOP, rejects, boundary, and load ignored in RUN.
        ev("stop_b", 0, 1, 0, 0, 8'h00);
        ev("load_42", 0, 0, 1, 0, 8'h42);
        ev("load_4A", 0, 0, 1, 0, 8'h4A);
        ev("load_60", 0, 0, 1, 0, 8'h60);
        ev("load_59", 0, 0, 1, 0, 8'h59);
        ev("load_42b", 0, 0, 1, 0, 8'h42);
        ev("start_c", 1, 0, 0, 0, 8'h00);
        ev("load_in_run", 0, 0, 1, 0, 8'h15);

        // Simultaneous events.
        ev("stop_c", 0, 1, 0, 0, 8'h00);
        ev("start_stop", 1, 1, 0, 0, 8'h00);
        ev("start_d", 1, 0, 0, 0, 8'h00);
        set_dir(1'b1);
        ev("tick_stop", 0, 1, 0, 1, 8'h00);
        ev("tick_in_stop", 0, 0, 0, 1, 8'h00);

        // Asynchronous reset mid-count at 37.
        ev("load_37", 0, 0, 1, 0, 8'h37);
        ev("start_e", 1, 0, 0, 0, 8'h00);
        @(posedge clk);
        #3;
        rst       = 1'b1;
        btn_start = 1'b1;
        #1;
        check("async_reset", 32'(obs), 32'h0);
        m_cnt = 8'h00;
        m_run = 1'b0;
        repeat (3) @(posedge clk);

        // Release with start held: exactly one start event.
        #1;
        t   = cyc_n;
        rst = 1'b0;
        push("held_release", t + 1, 12'h000, 12'hFFF);
        push("held_start_run", t + 3, 12'h008, 12'hFFF);
        push("held_no_tick", t + 10, 12'h008, 12'hFFF);
        repeat (12) @(posedge clk);
        #1;
        t        = cyc_n;
        btn_stop = 1'b1;
        push("held_stop", t + 3, 12'h000, 12'hFFF);
        push("held_no_restart", t + 15, 12'h000, 12'hFFF);
        repeat (6) @(posedge clk);
        #1;
        btn_stop = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        btn_start = 1'b0;
        repeat (5) @(posedge clk);
        #3;

        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
